receiver: RTL and testbench

Receive-side counterpart of the GMII frame sender. Strips preamble/SFD from incoming GMII frames and checks the Ethernet FCS. Writes each frame into the RX slot memory as a 7-word header followed by the frame bytes packed big-endian into 16-bit words. A frame is published to the host side only by advancing `mem_wr_ptr`. Sits between the PHY GMII RX pins and the RX slot RAM; the host reads slots via `mem_rd_ptr`.

---
 rtl/receiver.sv | 274 +++++++++++++++++++++++++++
 tb/tb_receiver.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/receiver.sv
// receiver: GMII receive path into the RX slot memory.
// Strips preamble/SFD, checks length, rx_er and space, and writes each frame
// as a 7-word header (length, timestamp, received FCS) plus big-endian data
// words. A frame becomes visible to the host only when mem_wr_ptr advances.
// Optional build macro: RX_FCS_CHECK_EN (drop frames whose FCS does not match).
// Ports:
//   gmii_rx_clk, sys_rst_n        clock, async active-low reset
//   global_counter                timestamp source, latched at SFD
//   gmii_rxd/_rx_dv/_rx_er        PHY receive pins
//   slot_rx_eth_*                 slot RAM write port (16-bit words)
//   mem_rd_ptr / mem_wr_ptr       host consumer / committed producer pointers
//   rx_good_count/rx_drop_count   saturating frame counters
module receiver #(
   parameter int unsigned MAX_LEN = 2047,
   parameter int unsigned MIN_LEN = 64
) (
   input  logic        gmii_rx_clk,
   input  logic        sys_rst_n,
   input  logic [63:0] global_counter,
   input  logic [7:0]  gmii_rxd,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   output logic [15:0] slot_rx_eth_data,
   output logic [1:0]  slot_rx_eth_byte_en,
   output logic [13:0] slot_rx_eth_addr,
   output logic        slot_rx_eth_wr_en,
   input  logic [13:0] mem_rd_ptr,
   output logic [13:0] mem_wr_ptr,
   output logic [15:0] rx_good_count,
   output logic [15:0] rx_drop_count
);

   localparam int unsigned AW        = 14;
   localparam int unsigned DW        = 16;
   localparam int unsigned CW        = 16;
   localparam int unsigned TW        = 64;
   localparam int unsigned HDR_WORDS = 7;
   localparam logic [CW-1:0] MAX_LEN_C   = CW'(MAX_LEN);
   localparam logic [CW-1:0] MIN_LEN_C   = CW'(MIN_LEN);
   localparam logic [AW-1:0] HDR_WORDS_A = AW'(HDR_WORDS);
   localparam logic [31:0]   CRC_POLY    = 32'hEDB8_8320;

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_DATA, S_HDR, S_COMMIT, S_DROP
   } state_t;

   // Reflected Ethernet CRC-32, one byte per call
   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      end
      return r;
   endfunction

   // GMII input register
   logic [7:0] rxd_q;
   logic       dv_q, er_q, dv_d_q;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]  wptr_q, wptr_d;
   logic [7:0]     pend_q, pend_d;
   logic [31:0]    crc_q, crc_d;
   logic [31:0]    dl_q, dl_d;
   logic [TW-1:0]  ts_q, ts_d;
   logic [2:0]     hidx_q, hidx_d;
   logic [DW-1:0]  data_q, data_d;
   logic [1:0]     be_q, be_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic           wr_en_q, wr_en_d;
   logic [AW-1:0]  wp_q, wp_d;
   logic [CW-1:0]  good_q, good_d;
   logic [CW-1:0]  drop_q, drop_d;

   logic [AW-1:0]  data_off, free_words;
   logic           data_full, frame_ok, enter_drop;
   logic [DW-1:0]  hdr_word;

   // Space check: the next data word must stay strictly behind mem_rd_ptr
   assign data_off   = wptr_q - wp_q;
   assign free_words = mem_rd_ptr - wp_q - AW'(1);
   assign data_full  = data_off > free_words;

`ifdef RX_FCS_CHECK_EN
   logic [31:0] fcs_exp;
   // First FCS byte on the wire is the low byte of the inverted CRC
   assign fcs_exp  = {~crc_q[7:0], ~crc_q[15:8], ~crc_q[23:16], ~crc_q[31:24]};
   assign frame_ok = (cnt_q >= MIN_LEN_C) && (dl_q == fcs_exp);
`else
   assign frame_ok = (cnt_q >= MIN_LEN_C);
`endif

   // Header word selected by hidx_q
   always_comb begin
      hdr_word = '0;
      case (hidx_q)
         3'd0:    hdr_word = cnt_q - CW'(4);
         3'd1:    hdr_word = ts_q[63:48];
         3'd2:    hdr_word = ts_q[47:32];
         3'd3:    hdr_word = ts_q[31:16];
         3'd4:    hdr_word = ts_q[15:0];
         3'd5:    hdr_word = dl_q[31:16];
         3'd6:    hdr_word = dl_q[15:0];
         default: hdr_word = '0;
      endcase
   end

   // Next-state and next-register logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wptr_d     = wptr_q;
      pend_d     = pend_q;
      crc_d      = crc_q;
      dl_d       = dl_q;
      ts_d       = ts_q;
      hidx_d     = hidx_q;
      data_d     = data_q;
      be_d       = be_q;
      addr_d     = addr_q;
      wr_en_d    = 1'b0;
      wp_d       = wp_q;
      good_d     = good_q;
      drop_d     = drop_q;
      enter_drop = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Only a fresh rx_dv rise starts a frame; late-rising frames are ignored
            if (dv_q && !dv_d_q && (rxd_q == 8'h55)) state_d = S_PREAMBLE;
         end
         S_PREAMBLE: begin
            if (!dv_q) begin
               state_d = S_IDLE;
            end else if (rxd_q == 8'hD5) begin
               state_d = S_DATA;
               ts_d    = global_counter;
               wptr_d  = wp_q + HDR_WORDS_A;
               cnt_d   = '0;
               crc_d   = '1;
               dl_d    = '0;
            end else if (rxd_q != 8'h55) begin
               state_d = S_IDLE;
            end
         end
         S_DATA: begin
            if (er_q) begin
               enter_drop = 1'b1;
            end else if (dv_q) begin
               if (cnt_q == MAX_LEN_C) begin
                  enter_drop = 1'b1;
               end else if (cnt_q[0] && data_full) begin
                  enter_drop = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
                  dl_d  = {dl_q[23:0], rxd_q};
                  // CRC sees a byte once it leaves the 4-byte delay line
                  if (cnt_q >= CW'(4)) crc_d = crc32_byte(crc_q, dl_q[31:24]);
                  if (!cnt_q[0]) begin
                     pend_d = rxd_q;
                  end else begin
                     wr_en_d = 1'b1;
                     addr_d  = wptr_q;
                     data_d  = {pend_q, rxd_q};
                     be_d    = 2'b11;
                     wptr_d  = wptr_q + AW'(1);
                  end
               end
            end else if (!frame_ok) begin
               enter_drop = 1'b1;
            end else if (cnt_q[0]) begin
               // Flush the odd trailing byte; header follows next cycle
               if (data_full) begin
                  enter_drop = 1'b1;
               end else begin
                  wr_en_d = 1'b1;
                  addr_d  = wptr_q;
                  data_d  = {pend_q, 8'h00};
                  be_d    = 2'b10;
                  wptr_d  = wptr_q + AW'(1);
                  hidx_d  = 3'd0;
                  state_d = S_HDR;
               end
            end else begin
               // No flush: issue header word 0 right away
               wr_en_d = 1'b1;
               addr_d  = wp_q;
               data_d  = cnt_q - CW'(4);
               be_d    = 2'b11;
               hidx_d  = 3'd1;
               state_d = S_HDR;
            end
         end
         S_HDR: begin
            wr_en_d = 1'b1;
            addr_d  = wp_q + AW'(hidx_q);
            data_d  = hdr_word;
            be_d    = 2'b11;
            if (hidx_q == 3'(HDR_WORDS - 1)) state_d = S_COMMIT;
            else                             hidx_d  = hidx_q + 3'd1;
         end
         S_COMMIT: begin
            wp_d    = wptr_q;
            good_d  = (good_q == '1) ? good_q : good_q + CW'(1);
            state_d = S_IDLE;
         end
         S_DROP: begin
            if (!dv_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (enter_drop) begin
         state_d = S_DROP;
         drop_d  = (drop_q == '1) ? drop_q : drop_q + CW'(1);
      end
   end

   // State and datapath registers
   always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rxd_q   <= '0;
         dv_q    <= 1'b0;
         er_q    <= 1'b0;
         dv_d_q  <= 1'b0;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wptr_q  <= '0;
         pend_q  <= '0;
         crc_q   <= '0;
         dl_q    <= '0;
         ts_q    <= '0;
         hidx_q  <= '0;
         data_q  <= '0;
         be_q    <= '0;
         addr_q  <= '0;
         wr_en_q <= 1'b0;
         wp_q    <= '0;
         good_q  <= '0;
         drop_q  <= '0;
      end else begin
         rxd_q   <= gmii_rxd;
         dv_q    <= gmii_rx_dv;
         er_q    <= gmii_rx_er;
         dv_d_q  <= dv_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
         pend_q  <= pend_d;
         crc_q   <= crc_d;
         dl_q    <= dl_d;
         ts_q    <= ts_d;
         hidx_q  <= hidx_d;
         data_q  <= data_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wr_en_q <= wr_en_d;
         wp_q    <= wp_d;
         good_q  <= good_d;
         drop_q  <= drop_d;
      end
   end

   assign slot_rx_eth_data    = data_q;
   assign slot_rx_eth_byte_en = be_q;
   assign slot_rx_eth_addr    = addr_q;
   assign slot_rx_eth_wr_en   = wr_en_q;
   assign mem_wr_ptr          = wp_q;
   assign rx_good_count       = good_q;
   assign rx_drop_count       = drop_q;

endmodule

// File: tb/tb_receiver.sv
// tb_receiver: directed frames into receiver; expected slot writes are queued
// as bytes are driven and matched against each write strobe.
module tb_receiver;

   localparam int unsigned MAX_LEN = 2047;
   localparam int unsigned MIN_LEN = 64;
`ifdef RX_FCS_CHECK_EN
   localparam bit FCS_CHK = 1'b1;
`else
   localparam bit FCS_CHK = 1'b0;
`endif

   typedef struct packed {
      logic [13:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
   } wr_t;

   logic        gmii_rx_clk = 1'b0;
   logic        sys_rst_n;
   logic [63:0] global_counter = 64'h0123_4567_89AB_0000;
   logic [7:0]  gmii_rxd;
   logic        gmii_rx_dv;
   logic        gmii_rx_er;
   logic [15:0] slot_rx_eth_data;
   logic [1:0]  slot_rx_eth_byte_en;
   logic [13:0] slot_rx_eth_addr;
   logic        slot_rx_eth_wr_en;
   logic [13:0] mem_rd_ptr;
   logic [13:0] mem_wr_ptr;
   logic [15:0] rx_good_count;
   logic [15:0] rx_drop_count;

   int          errors = 0;
   int          checks = 0;
   wr_t         exp_q[$];
   logic [7:0]  fb[$];
   logic [13:0] exp_wp = '0;
   logic [15:0] exp_good = '0;
   logic [15:0] exp_drop = '0;

   receiver #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
      .gmii_rx_clk(gmii_rx_clk), .sys_rst_n(sys_rst_n),
      .global_counter(global_counter),
      .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
      .slot_rx_eth_data(slot_rx_eth_data), .slot_rx_eth_byte_en(slot_rx_eth_byte_en),
      .slot_rx_eth_addr(slot_rx_eth_addr), .slot_rx_eth_wr_en(slot_rx_eth_wr_en),
      .mem_rd_ptr(mem_rd_ptr), .mem_wr_ptr(mem_wr_ptr),
      .rx_good_count(rx_good_count), .rx_drop_count(rx_drop_count)
   );

   always #4 gmii_rx_clk = ~gmii_rx_clk;
   always @(posedge gmii_rx_clk) global_counter <= global_counter + 64'd1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest queued expectation
   always @(negedge gmii_rx_clk) begin
      if (sys_rst_n && slot_rx_eth_wr_en) begin
         if (exp_q.size() == 0) begin
            chk("slot_wr_extra", 64'(exp_q.size()), 64'd1);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            chk("slot_wr", 64'({slot_rx_eth_addr, slot_rx_eth_data, slot_rx_eth_byte_en}), 64'(w));
         end
      end
   end

   task automatic drive(input logic [7:0] d, input logic dv, input logic er);
      @(negedge gmii_rx_clk);
      gmii_rxd   = d;
      gmii_rx_dv = dv;
      gmii_rx_er = er;
   endtask

   // Payload of n-4 random bytes followed by its Ethernet FCS
   task automatic build_frame(input int n, input bit corrupt);
      logic [31:0] c;
      fb.delete();
      for (int i = 0; i < n - 4; i++) fb.push_back(8'($urandom));
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n - 4; i++) begin
         c = c ^ {24'h0, fb[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      c = ~c;
      fb.push_back(c[7:0]);
      fb.push_back(c[15:8]);
      fb.push_back(c[23:16]);
      fb.push_back(c[31:24]);
      if (corrupt) fb[n-2] = fb[n-2] ^ 8'h5A;
   endtask

   task automatic push_wr(input logic [13:0] a, input logic [15:0] d, input logic [1:0] be);
      wr_t w;
      w.addr = a;
      w.data = d;
      w.be   = be;
      exp_q.push_back(w);
   endtask

   // Drive fb as one frame (er_at = byte index with rx_er, n = at dv fall, -1 none)
   task automatic send_frame(input string tag, input int er_at, input bit fcs_ok);
      int          n, w;
      logic [13:0] s, free;
      logic [63:0] ts;
      bit          drop;
      n    = fb.size();
      s    = exp_wp;
      free = mem_rd_ptr - s - 14'd1;
      drop = 1'b0;
      for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
      drive(8'hD5, 1'b1, 1'b0);
      ts = global_counter + 64'd1;
      for (int k = 0; k < n; k++) begin
         drive(fb[k], 1'b1, k == er_at);
         if (!drop) begin
            if (k == er_at || k + 1 > MAX_LEN) begin
               drop = 1'b1;
            end else if (k % 2 == 1) begin
               w = 7 + k / 2;
               if (14'(w) > free) drop = 1'b1;
               else push_wr(14'(int'(s) + w), {fb[k-1], fb[k]}, 2'b11);
            end
         end
      end
      drive(8'h00, 1'b0, er_at == n);
      if (!drop) begin
         if (er_at == n || n < MIN_LEN || (FCS_CHK && !fcs_ok)) begin
            drop = 1'b1;
         end else begin
            if (n % 2 == 1) begin
               w = 7 + n / 2;
               if (14'(w) > free) drop = 1'b1;
               else push_wr(14'(int'(s) + w), {fb[n-1], 8'h00}, 2'b10);
            end
            if (!drop) begin
               push_wr(s,          16'(n - 4),         2'b11);
               push_wr(s + 14'd1, ts[63:48],           2'b11);
               push_wr(s + 14'd2, ts[47:32],           2'b11);
               push_wr(s + 14'd3, ts[31:16],           2'b11);
               push_wr(s + 14'd4, ts[15:0],            2'b11);
               push_wr(s + 14'd5, {fb[n-4], fb[n-3]},  2'b11);
               push_wr(s + 14'd6, {fb[n-2], fb[n-1]},  2'b11);
               exp_wp   = 14'(int'(s) + 7 + (n + 1) / 2);
               exp_good = exp_good + 16'd1;
            end
         end
      end
      if (drop) exp_drop = exp_drop + 16'd1;
      repeat (15) drive(8'h00, 1'b0, 1'b0);
      chk({tag, "_wr_ptr"}, 64'(mem_wr_ptr), 64'(exp_wp));
      chk({tag, "_good"}, 64'(rx_good_count), 64'(exp_good));
      chk({tag, "_drop"}, 64'(rx_drop_count), 64'(exp_drop));
      chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int rem, w, len;
      sys_rst_n  = 1'b0;
      gmii_rxd   = 8'h00;
      gmii_rx_dv = 1'b0;
      gmii_rx_er = 1'b0;
      mem_rd_ptr = '0;
      repeat (3) @(negedge gmii_rx_clk);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge gmii_rx_clk);
      chk("rst_wr_en", 64'(slot_rx_eth_wr_en), 64'd0);
      chk("rst_data", 64'(slot_rx_eth_data), 64'd0);
      chk("rst_be", 64'(slot_rx_eth_byte_en), 64'd0);
      chk("rst_addr", 64'(slot_rx_eth_addr), 64'd0);
      chk("rst_wr_ptr", 64'(mem_wr_ptr), 64'd0);
      chk("rst_good", 64'(rx_good_count), 64'd0);
      chk("rst_drop", 64'(rx_drop_count), 64'd0);

      // Minimum-length good frame: mem_wr_ptr 39
      build_frame(64, 1'b0);
      send_frame("f64", -1, 1'b1);
      chk("f64_ptr39", 64'(mem_wr_ptr), 64'd39);

      // Odd length: flush word with byte_en 2'b10, advance 40
      mem_rd_ptr = exp_wp;
      build_frame(65, 1'b0);
      send_frame("f65", -1, 1'b1);
      chk("f65_ptr79", 64'(mem_wr_ptr), 64'd79);

      // Corrupted FCS byte
      mem_rd_ptr = exp_wp;
      build_frame(64, 1'b1);
      send_frame("badfcs", -1, 1'b0);

      // rx_er mid-frame
      mem_rd_ptr = exp_wp;
      build_frame(100, 1'b0);
      send_frame("rxer20", 20, 1'b1);

      // One byte below MIN_LEN
      mem_rd_ptr = exp_wp;
      build_frame(63, 1'b0);
      send_frame("short63", -1, 1'b1);

      // rx_er coincident with rx_dv fall
      mem_rd_ptr = exp_wp;
      build_frame(70, 1'b0);
      send_frame("erfall", 70, 1'b1);

      // One byte above MAX_LEN
      mem_rd_ptr = exp_wp;
      build_frame(2048, 1'b0);
      send_frame("long2048", -1, 1'b1);

      // Fill the ring up to mem_wr_ptr = 16380 with accepted frames
      for (int f = 0; f < 40 && exp_wp != 14'd16380; f++) begin
         rem = 16380 - int'(exp_wp);
         if (rem > 1070)      w = 1031;
         else if (rem > 1031) w = rem - 39;
         else                 w = rem;
         len = 2 * (w - 7);
         if (len > int'(MAX_LEN)) len = len - 1;
         mem_rd_ptr = exp_wp;
         build_frame(len, 1'b0);
         send_frame("fill", -1, 1'b1);
      end
      chk("fill_ptr16380", 64'(mem_wr_ptr), 64'd16380);

      // Only 3 free words ahead of the slot: frame must be dropped
      mem_rd_ptr = 14'd0;
      build_frame(64, 1'b0);
      send_frame("full", -1, 1'b1);
      chk("full_ptr_hold", 64'(mem_wr_ptr), 64'd16380);

      // Enough space: slot wraps past address 16383
      mem_rd_ptr = 14'd100;
      build_frame(64, 1'b0);
      send_frame("wrap", -1, 1'b1);
      chk("wrap_ptr35", 64'(mem_wr_ptr), 64'd35);

      // Reset in the middle of a frame: nothing committed
      mem_rd_ptr = exp_wp;
      build_frame(64, 1'b0);
      for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
      drive(8'hD5, 1'b1, 1'b0);
      drive(fb[0], 1'b1, 1'b0);
      drive(fb[1], 1'b1, 1'b0);
      @(negedge gmii_rx_clk);
      sys_rst_n  = 1'b0;
      gmii_rx_dv = 1'b0;
      gmii_rxd   = 8'h00;
      repeat (3) @(negedge gmii_rx_clk);
      sys_rst_n = 1'b1;
      exp_q.delete();
      exp_wp   = '0;
      exp_good = '0;
      exp_drop = '0;
      repeat (4) @(negedge gmii_rx_clk);
      chk("midrst_wr_ptr", 64'(mem_wr_ptr), 64'd0);
      chk("midrst_good", 64'(rx_good_count), 64'd0);
      chk("midrst_drop", 64'(rx_drop_count), 64'd0);

      mem_rd_ptr = 14'd0;
      build_frame(64, 1'b0);
      send_frame("postrst", -1, 1'b1);
      chk("postrst_ptr39", 64'(mem_wr_ptr), 64'd39);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
